video_pll_reset_sequencer: RTL and testbench
============================================

# video_pll_reset_sequencer

Controls the video PLL's reset and lock sequence, and releases the resets of the three clock domains it drives (outclk_0, outclk_1, outclk_2) in a fixed order. It sits between the board-level reset and the video PLL, in the PLL's reference-clock domain. It also retries a PLL that fails to lock, re-sequences after a loss of lock, and reports status to software.

## Interface
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per lock attempt (≥1).
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz).
- LOCK_STABLE, 1024: consecutive synchronized locked cycles required before release (≥2).
- MAX_RETRIES, 3: extra attempts after the first before FAULT (≤15).
- RELEASE_GAP, 8: cycles between successive domain reset releases (≥1).

Ports:
- refclk  in  1  clock, 50 MHz, same net as the PLL reference clock.
- rst  in  1  one clock; reset is synchronous and active-high.
- pll_locked  in  1  PLL locked output (asynchronous); double-flop synchronized internally to locked_s, with sync flops resetting to 0.
- relock_req  in  1  single-cycle request to restart the sequence.
- pll_rst  out  1  drives PLL rst; reset value 1.
- dom_rst  out  3  active-high resets for outclk_0..2 domains; reset value 3'b111.
- ready  out  1  all domains released; reset value 0.
- fault  out  1  sticky lock failure; reset value 0.
- retry_cnt  out  4  failed attempts in the current sequence; reset value 0.
- lock_loss_cnt  out  8  lock losses seen in RUN, saturating at 255; reset value 0.

## Operation
- All outputs are registered.
- FSM states: PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT. The reset state is PLL_RESET.
- One shared cycle counter, cnt, cleared on every state entry.
- **PLL_RESET**
  - pll_rst=1, dom_rst=111, ready=0.
  - After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- **WAIT_LOCK**
  - pll_rst=0.
  - locked_s=1: go to STABLE, with cnt=1.
  - LOCK_TIMEOUT cycles elapse without lock and retry_cnt<MAX_RETRIES: retry_cnt++, go to PLL_RESET.
  - LOCK_TIMEOUT cycles elapse without lock and retry_cnt==MAX_RETRIES: go to FAULT.
- **STABLE**
  - Each locked_s=1 cycle increments cnt.
  - cnt reaches LOCK_STABLE: go to RELEASE and clear dom_rst[0] on the same edge.
  - locked_s=0: go back to WAIT_LOCK. The timeout restarts and retry_cnt is unchanged.
- **RELEASE**
  - dom_rst[1] clears RELEASE_GAP cycles after dom_rst[0].
  - dom_rst[2] clears RELEASE_GAP cycles after dom_rst[1].
  - On the same edge that clears dom_rst[2]: ready=1, retry_cnt=0, state=RUN.
- **RUN**
  - locked_s=0: lock_loss_cnt++ (saturating), then go to PLL_RESET. On that edge pll_rst=1, dom_rst=111 and ready=0.
  - A lock loss during RELEASE is handled the same way.
- **FAULT**
  - pll_rst=1, dom_rst=111, ready=0, fault=1.
  - Left only via rst or relock_req.
- **relock_req**
  - Accepted in WAIT_LOCK, STABLE, RELEASE, RUN and FAULT.
  - Effect: clear fault and retry_cnt, go to PLL_RESET. lock_loss_cnt is not incremented.
  - Ignored in PLL_RESET.
- **Priority when events coincide:** rst > lock loss > relock_req > timeout/stable completion.
  - Lock loss and relock_req in the same RUN cycle count as one lock loss.
- **Reset mid-operation:** rst in any state returns every output to its reset value on the next edge, including fault and both counters.

## Timing
- pll_locked to locked_s latency: 2 edges.
- Clean power-up with pll_locked already high:
  - pll_rst falls at edge PLL_RST_CYCLES after rst deasserts.
  - Call e0 the edge that first samples pll_locked=1 in WAIT_LOCK.
  - dom_rst[0] falls at e0+LOCK_STABLE+1.
  - dom_rst[1] falls RELEASE_GAP edges later.
  - dom_rst[2] falls and ready rises 2·RELEASE_GAP edges after dom_rst[0].
- Lock loss in RUN: with e0 the edge sampling pll_locked=0, pll_rst=1, dom_rst=111, ready=0 and the updated lock_loss_cnt are visible after e0+2.
- A pll_locked low pulse one cycle wide is not filtered; it is treated as a loss of lock.
- relock_req reaction: outputs change on the next edge.

## Test plan
All tests use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=4, MAX_RETRIES=2, RELEASE_GAP=3.

1. Release rst with pll_locked=1 from the start -> pll_rst high 4 cycles; with e0 the first WAIT_LOCK edge, dom_rst = 110 at e0+5, 100 at e0+8, 000 with ready=1 at e0+11; retry_cnt=0, fault=0.
2. pll_locked held 0 -> three 20-cycle WAIT_LOCK windows; retry_cnt 1 then 2; then fault=1, pll_rst=1, dom_rst=111. Pulse relock_req -> fault=0, retry_cnt=0, pll_rst high 4 cycles then low.
3. pll_locked high 2 cycles then low, inside STABLE -> dom_rst stays 111, retry_cnt unchanged; then hold high -> release completes 5/8/11 edges later, as in test 1.
4. In RUN, drop pll_locked for 1 cycle -> 2 edges later ready=0, dom_rst=111, pll_rst=1, lock_loss_cnt=1; full re-sequence follows.
5. In RUN, drop pll_locked and pulse relock_req so both reach the FSM on the same cycle -> lock_loss_cnt increments by exactly 1. Force 256 losses -> lock_loss_cnt holds 255.
6. Assert rst for 1 cycle while in RELEASE with dom_rst=100 -> next edge: dom_rst=111, pll_rst=1, ready=0, fault=0, both counters 0.

Source files
------------

// File: rtl/video_pll_reset_sequencer.sv
// video_pll_reset_sequencer
// Sequences the video PLL reset/lock handshake and releases the resets of the
// three PLL output clock domains in order (outclk_0, then 1, then 2). Retries
// failed lock attempts, re-sequences after lock loss and reports status.
// Runs entirely in the PLL reference-clock domain.
//
// Ports:
//   refclk_i         reference clock (same net as the PLL refclk)
//   rst_i            synchronous active-high reset
//   pll_locked_i     asynchronous PLL locked indication
//   relock_req_i     single-cycle request to restart the sequence
//   pll_rst_o        PLL reset (reset value 1)
//   dom_rst_o[2:0]   active-high resets for outclk_0..2 domains (reset 3'b111)
//   ready_o          all domains released
//   fault_o          sticky lock failure after all retries
//   retry_cnt_o      failed lock attempts in the current sequence
//   lock_loss_cnt_o  lock losses seen after release, saturating at 255
module video_pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned RELEASE_GAP    = 8
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       relock_req_i,
  output logic       pll_rst_o,
  output logic [2:0] dom_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int unsigned MAX_A   = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int unsigned MAX_B   = (PLL_RST_CYCLES > 2 * RELEASE_GAP) ? PLL_RST_CYCLES
                                                                        : 2 * RELEASE_GAP;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pll_rst_q;
  logic [2:0]       dom_rst_q;
  logic             ready_q;
  logic             fault_q;
  logic [3:0]       retry_q;
  logic [7:0]       lock_loss_q;
  logic             sync1_q;
  logic             locked_s_q;

  logic             lock_lost_c;
  logic             stable_drop_c;
  logic             relock_c;

  // Lock synchronizer. The lock output is meaningless while the PLL is held
  // in reset, so the synchronizer is kept cleared then; every attempt starts
  // from an unlocked view and cannot be fooled by a stale lock.
  always_ff @(posedge refclk_i) begin
    if (rst_i || pll_rst_q) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked_i;
      locked_s_q <= sync1_q;
    end
  end

  // Event decode, in priority order: lock loss, relock request, then the
  // per-state timeout/completion handled inside the FSM.
  always_comb begin
    lock_lost_c   = !locked_s_q && ((state_q == S_RELEASE) || (state_q == S_RUN));
    stable_drop_c = !locked_s_q && (state_q == S_STABLE);
    relock_c      = relock_req_i && (state_q != S_PLL_RESET);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q     <= S_PLL_RESET;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      dom_rst_q   <= 3'b111;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= 4'd0;
      lock_loss_q <= 8'd0;
    end else if (lock_lost_c) begin
      state_q   <= S_PLL_RESET;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_rst_q <= 3'b111;
      ready_q   <= 1'b0;
      if (lock_loss_q != 8'hFF) begin
        lock_loss_q <= lock_loss_q + 8'd1;
      end
    end else if (stable_drop_c) begin
      // Lock dropped before it was proven stable: wait again with a fresh timeout.
      state_q <= S_WAIT_LOCK;
      cnt_q   <= '0;
    end else if (relock_c) begin
      state_q   <= S_PLL_RESET;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_rst_q <= 3'b111;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      retry_q   <= 4'd0;
    end else begin
      case (state_q)
        S_PLL_RESET: begin
          if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s_q) begin
            // The cycle that sees lock already counts toward stability.
            state_q <= S_STABLE;
            cnt_q   <= CNT_W'(1);
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q < 4'(MAX_RETRIES)) begin
              state_q <= S_PLL_RESET;
              retry_q <= retry_q + 4'd1;
            end else begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          // locked_s is known high here; a drop was taken above.
          if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
            state_q      <= S_RELEASE;
            cnt_q        <= '0;
            dom_rst_q[0] <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (cnt_q == CNT_W'(2 * RELEASE_GAP - 1)) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            dom_rst_q <= 3'b000;
            ready_q   <= 1'b1;
            retry_q   <= 4'd0;
          end else begin
            if (cnt_q == CNT_W'(RELEASE_GAP - 1)) begin
              dom_rst_q[1] <= 1'b0;
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          cnt_q <= '0;
        end
        S_FAULT: begin
          cnt_q <= '0;
        end
        default: begin
          state_q   <= S_PLL_RESET;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          dom_rst_q <= 3'b111;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign dom_rst_o       = dom_rst_q;
  assign ready_o         = ready_q;
  assign fault_o         = fault_q;
  assign retry_cnt_o     = retry_q;
  assign lock_loss_cnt_o = lock_loss_q;

endmodule

// File: tb/tb_video_pll_reset_sequencer.sv
// Testbench for video_pll_reset_sequencer. Stimulus runs on falling edges and
// queues the expected output snapshot for a given rising edge; a separate
// monitor samples 2 ns after each rising edge and compares due entries.
module tb_video_pll_reset_sequencer;

  localparam int unsigned PRC = 4;
  localparam int unsigned TO  = 20;
  localparam int unsigned LS  = 4;
  localparam int unsigned MR  = 2;
  localparam int unsigned RG  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic [2:0] dom_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  video_pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (TO),
    .LOCK_STABLE   (LS),
    .MAX_RETRIES   (MR),
    .RELEASE_GAP   (RG)
  ) dut (
    .refclk_i       (clk),
    .rst_i          (rst),
    .pll_locked_i   (pll_locked),
    .relock_req_i   (relock_req),
    .pll_rst_o      (pll_rst),
    .dom_rst_o      (dom_rst),
    .ready_o        (ready),
    .fault_o        (fault),
    .retry_cnt_o    (retry_cnt),
    .lock_loss_cnt_o(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         due;
    string      name;
    logic       pll;
    logic [2:0] dom;
    logic       rdy;
    logic       flt;
    logic [3:0] rc;
    logic [7:0] llc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  // Queue the expected outputs as seen after the k-th rising edge from now.
  task automatic expect_at(input int k, input string nm, input logic p, input logic [2:0] d,
                           input logic r, input logic f, input logic [3:0] rc,
                           input logic [7:0] lc);
    exp_t e;
    e.due  = edge_n + k;
    e.name = nm;
    e.pll  = p;
    e.dom  = d;
    e.rdy  = r;
    e.flt  = f;
    e.rc   = rc;
    e.llc  = lc;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input string fld, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got %0d, required %0d", nm, fld, act, req);
    end
  endtask

  // Monitor: compare every queued snapshot that falls due on this edge.
  initial begin : monitor
    exp_t e;
    int   idle;
    idle = 0;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() != 0 && sb[0].due <= edge_n) begin
        e = sb.pop_front();
        if (e.due != edge_n) begin
          checks++;
          errors++;
          $display("FAIL %s sample_edge: got %0d, required %0d", e.name, edge_n, e.due);
        end
        chk(e.name, "pll_rst",       8'(pll_rst),   8'(e.pll));
        chk(e.name, "dom_rst",       8'(dom_rst),   8'(e.dom));
        chk(e.name, "ready",         8'(ready),     8'(e.rdy));
        chk(e.name, "fault",         8'(fault),     8'(e.flt));
        chk(e.name, "retry_cnt",     8'(retry_cnt), 8'(e.rc));
        chk(e.name, "lock_loss_cnt", lock_loss_cnt, e.llc);
      end
      if (stim_done) begin
        idle++;
        if (sb.size() == 0 || idle > 50) begin
          while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never_sampled: got edge %0d, required edge %0d", e.name, edge_n, e.due);
          end
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $finish;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of run by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst        = 1'b1;
    pll_locked = 1'b1;
    relock_req = 1'b0;
    step(3);
    expect_at(1, "reset", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    step(1);
    rst = 1'b0;

    // Clean power-up with lock present; first WAIT_LOCK edge is +5.
    expect_at(3,  "t1_pll_hold",  1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(4,  "t1_pll_fall",  1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(9,  "t1_pre_rel",   1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(10, "t1_dom0",      1'b0, 3'b110, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(12, "t1_dom0_hold", 1'b0, 3'b110, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(13, "t1_dom1",      1'b0, 3'b100, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(15, "t1_dom1_hold", 1'b0, 3'b100, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(16, "t1_ready",     1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd0);
    step(20);

    // One-cycle lock glitch in RUN, then full re-sequence.
    pll_locked = 1'b0;
    expect_at(2,  "t4_before",    1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd0);
    expect_at(3,  "t4_loss",      1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd1);
    expect_at(6,  "t4_pll_hold",  1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd1);
    expect_at(7,  "t4_pll_fall",  1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd1);
    expect_at(12, "t4_pre_rel",   1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd1);
    expect_at(13, "t4_dom0",      1'b0, 3'b110, 1'b0, 1'b0, 4'd0, 8'd1);
    expect_at(16, "t4_dom1",      1'b0, 3'b100, 1'b0, 1'b0, 4'd0, 8'd1);
    expect_at(19, "t4_ready",     1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd1);
    step(1);
    pll_locked = 1'b1;
    step(19);

    // Lock loss and relock_req reach the FSM on the same edge: one loss.
    pll_locked = 1'b0;
    expect_at(2,  "t5_before",    1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd1);
    expect_at(3,  "t5_both",      1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd2);
    expect_at(19, "t5_ready",     1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd2);
    step(1);
    pll_locked = 1'b1;
    step(1);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    step(17);

    // 256 more losses: counter climbs 3..254, then holds at 255.
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b0;
      if (i == 251) begin
        expect_at(3, "t5_cnt254", 1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd254);
      end
      if (i == 252 || i == 255) begin
        expect_at(3,  "t5_sat",     1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd255);
        expect_at(19, "t5_sat_run", 1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd255);
      end
      step(1);
      pll_locked = 1'b1;
      step(19);
    end

    // Reset pulse in RELEASE with dom_rst=100 clears everything.
    pll_locked = 1'b0;
    expect_at(16, "t6_dom100", 1'b0, 3'b100, 1'b0, 1'b0, 4'd0, 8'd255);
    expect_at(17, "t6_reset",  1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    step(1);
    pll_locked = 1'b1;
    step(15);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    pll_locked = 1'b0;

    // No lock: three timeout windows, fault, relock, then a lock flicker in STABLE.
    expect_at(4,   "t2_pll_fall",   1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(23,  "t2_win1_end",   1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(24,  "t2_retry1",     1'b1, 3'b111, 1'b0, 1'b0, 4'd1, 8'd0);
    expect_at(28,  "t2_pll_fall1",  1'b0, 3'b111, 1'b0, 1'b0, 4'd1, 8'd0);
    expect_at(48,  "t2_retry2",     1'b1, 3'b111, 1'b0, 1'b0, 4'd2, 8'd0);
    expect_at(52,  "t2_pll_fall2",  1'b0, 3'b111, 1'b0, 1'b0, 4'd2, 8'd0);
    expect_at(71,  "t2_win3_end",   1'b0, 3'b111, 1'b0, 1'b0, 4'd2, 8'd0);
    expect_at(72,  "t2_fault",      1'b1, 3'b111, 1'b0, 1'b1, 4'd2, 8'd0);
    expect_at(75,  "t2_fault_hold", 1'b1, 3'b111, 1'b0, 1'b1, 4'd2, 8'd0);
    expect_at(76,  "t2_relock",     1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(79,  "t2_pll_hold",   1'b1, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(80,  "t2_pll_fall3",  1'b0, 3'b111, 1'b0, 1'b0, 4'd0, 8'd0);
    expect_at(100, "t3_retry",      1'b1, 3'b111, 1'b0, 1'b0, 4'd1, 8'd0);
    expect_at(110, "t3_stable",     1'b0, 3'b111, 1'b0, 1'b0, 4'd1, 8'd0);
    expect_at(111, "t3_back",       1'b0, 3'b111, 1'b0, 1'b0, 4'd1, 8'd0);
    expect_at(117, "t3_pre_rel",    1'b0, 3'b111, 1'b0, 1'b0, 4'd1, 8'd0);
    expect_at(118, "t3_dom0",       1'b0, 3'b110, 1'b0, 1'b0, 4'd1, 8'd0);
    expect_at(121, "t3_dom1",       1'b0, 3'b100, 1'b0, 1'b0, 4'd1, 8'd0);
    expect_at(124, "t3_ready",      1'b0, 3'b000, 1'b1, 1'b0, 4'd0, 8'd0);
    step(75);
    relock_req = 1'b1;
    step(1);
    relock_req = 1'b0;
    step(30);
    pll_locked = 1'b1;
    step(2);
    pll_locked = 1'b0;
    step(4);
    pll_locked = 1'b1;
    step(14);
    stim_done = 1'b1;
  end

endmodule
